// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - debounced button level to short/long/repeat events and press count
module button_event_decoder #(
    parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
    parameter int unsigned REPEAT_CYCLES     = 25_000_000,
    parameter int unsigned CNT_WIDTH         = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 signal_i,
    output logic                 short_press_o,
    output logic                 long_press_o,
    output logic                 repeat_o,
    output logic                 held_o,
    output logic [CNT_WIDTH-1:0] press_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

    // Timer values at which the long-press and repeat thresholds are reached.
    // The timer counts high samples already seen, so the match is one below
    // the configured cycle count.
    localparam logic [31:0]          LONG_LAST   = 32'(LONG_PRESS_CYCLES - 32'd1);
    localparam logic [31:0]          REPEAT_LAST = 32'(REPEAT_CYCLES - 32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

    state_t                 state_q, state_d;
    logic                   prev_q;
    logic [31:0]            timer_q, timer_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   short_q, short_d;
    logic                   long_q, long_d;
    logic                   repeat_q, repeat_d;
    logic                   held_q, held_d;

    // Next-state and event decode; pulses are produced here and registered below.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only a genuine low-to-high transition starts a press; prev_q
                // comes out of reset high so a button held through reset is
                // ignored until it has been released once.
                if (signal_i && !prev_q) begin
                    state_d = ST_PRESSED;
                    timer_d = 32'd1;
                    count_d = count_q + CNT_ONE;
                end
            end

            ST_PRESSED: begin
                if (signal_i) begin
                    if (timer_q == LONG_LAST) begin
                        state_d = ST_LONG;
                        timer_d = 32'd0;
                        long_d  = 1'b1;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                    short_d = 1'b1;
                end
            end

            ST_LONG: begin
                // After a long press the timer restarts and paces repeats;
                // releasing from here produces no further event.
                if (signal_i) begin
                    if (timer_q == REPEAT_LAST) begin
                        timer_d  = 32'd0;
                        repeat_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 32'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = 32'd0;
            end
        endcase

        // held follows the state register, so it is computed from the next state.
        held_d = (state_d != ST_IDLE);
    end

    // State, timer, counter and registered outputs; reset abandons any press silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            prev_q   <= 1'b1;
            timer_q  <= 32'd0;
            count_q  <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= signal_i;
            timer_q  <= timer_d;
            count_q  <= count_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            held_q   <= held_d;
        end
    end

    assign short_press_o = short_q;
    assign long_press_o  = long_q;
    assign repeat_o      = repeat_q;
    assign held_o        = held_q;
    assign press_count_o = count_q;

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the debounce stage and consumes its clean, debounced button level.
- Turns that level into discrete user events: short press (on release), long press, auto-repeat while held, and a running press count.
- All outputs are registered, so UI and control logic can use them without further conditioning.

Parameters:
- LONG_PRESS_CYCLES, default 100_000_000: consecutive high samples that qualify a long press. Must be ≥ 2 and < 2^32.
- REPEAT_CYCLES, default 25_000_000: additional consecutive high samples between auto-repeat pulses after a long press. Must be ≥ 2 and < 2^32.
- CNT_WIDTH, default 8: width of the press counter.

Ports:
- clk_i  input  1  system clock; all logic on the rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- signal_i  input  1  debounced button level (1 = pressed), already clean and synchronous to clk_i.
- short_press_o  output  1  one-cycle pulse: released before the long threshold.
- long_press_o  output  1  one-cycle pulse: hold reached LONG_PRESS_CYCLES.
- repeat_o  output  1  one-cycle pulse: every REPEAT_CYCLES of further hold after a long press.
- held_o  output  1  level: a qualified press is in progress.
- press_count_o  output  CNT_WIDTH  number of qualified presses, modulo 2^CNT_WIDTH.

Behaviour:
- Registers:
  - prev_q: previous signal_i sample.
  - 32-bit hold timer.
  - state.
  - press counter.
  - registered outputs.
- Reset (rst_i high at an edge):
  - state = ST_IDLE, timer = 0, press counter = 0.
  - short_press_o, long_press_o, repeat_o and held_o = 0.
  - prev_q = 1, so a button already held out of reset is ignored until it has been seen low once.
  - Reset overrides every other action, including mid-press: no pulse is emitted for an interrupted press.
- ST_IDLE:
  - On a sample with signal_i=1 and prev_q=0 (rising edge): go to ST_PRESSED, timer = 1, press counter +1.
  - Otherwise stay in ST_IDLE.
- ST_PRESSED:
  - On each sample with signal_i=1:
    - If timer == LONG_PRESS_CYCLES-1: go to ST_LONG, timer = 0, long_press_o = 1 for the next cycle.
    - Otherwise: timer +1.
  - On a sample with signal_i=0: go to ST_IDLE, short_press_o = 1 for the next cycle.
- ST_LONG:
  - On each sample with signal_i=1:
    - If timer == REPEAT_CYCLES-1: timer = 0, repeat_o = 1 for the next cycle.
    - Otherwise: timer +1.
  - On a sample with signal_i=0: go to ST_IDLE. No short_press_o and no repeat_o are emitted.
- Resulting event timing (H = number of consecutive high samples of the press):
  - H < LONG_PRESS_CYCLES: exactly one short_press_o, in the cycle after the first low sample.
  - H ≥ LONG_PRESS_CYCLES: long_press_o in the cycle after the LONG_PRESS_CYCLES-th high sample, and no short press.
  - H ≥ LONG_PRESS_CYCLES + k*REPEAT_CYCLES: k repeat pulses, each in the cycle after the qualifying sample.
- held_o:
  - 1 in every cycle where the registered state is ST_PRESSED or ST_LONG; 0 otherwise.
  - Rises one cycle after the rising-edge sample.
- press_count_o:
  - Updates in the cycle after the rising-edge sample.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Pulse exclusivity: at most one of short_press_o, long_press_o and repeat_o is high in any cycle. Each pulse lasts exactly one cycle.
- A 1-cycle press (H=1) is a valid short press: the counter increments and short_press_o pulses.
- Back-to-back presses:
  - Release and re-press on consecutive samples (1,0,1) count as two presses.
  - The second press starts from ST_IDLE on the next rising edge.
- The timer never overflows: it is bounded by the parameter limits.

Test Plan:
(Bench parameters: LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4, CNT_WIDTH=4.)
- Reset, signal_i=0: hold rst_i high 2 cycles -> all outputs 0, press_count_o=0.
- Short press: signal_i high 7 cycles then low -> exactly one short_press_o, 1 cycle after the first low sample; no long_press_o or repeat_o; press_count_o=1.
- Long threshold: signal_i high 8 cycles then low -> long_press_o 1 cycle after the 8th high sample; no short_press_o; no repeat_o; held_o drops 1 cycle after the low sample.
- Auto-repeat: signal_i high 20 cycles -> long_press_o after sample 8; repeat_o after samples 12, 16 and 20 (3 pulses); press_count_o=1.
- Held through reset: signal_i=1 during and after reset, for 20 cycles -> no events, held_o=0, count=0. Then release, then press 3 cycles -> one short_press_o, count=1.
- Wrap and mid-press reset:
  - 17 one-cycle presses separated by one low cycle -> 17 short_press_o pulses, press_count_o=1.
  - Then assert rst_i at the 5th high cycle of a press -> no pulse, count=0, state ST_IDLE.
